// File: rtl/wb_port_arbiter_pkg.sv
// Shared widths, FSM encoding and the hard-wired zero register index for the
// register-file write-port arbiter.
package wb_port_arbiter_pkg;

  localparam int WB_REG_WIDTH  = 32;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int X0_REG        = 0;
  localparam int STARVE_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_port_arbiter_hold_buf.sv
// One-entry holding buffer for an MDU result waiting for the write port.
module wb_hold_buf
  import wb_port_arbiter_pkg::*;
#(
  parameter int REG_WIDTH  = WB_REG_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [ADDR_WIDTH-1:0] load_rd,
  input  logic [REG_WIDTH-1:0]  load_data,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] rd,
  output logic [REG_WIDTH-1:0]  data
);

  logic                  vld_p0;
  logic [ADDR_WIDTH-1:0] rd_p0;
  logic [REG_WIDTH-1:0]  data_p0;

  // Capture stage: rd is visible to the hazard unit, so it resets with valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0 <= 1'b0;
      rd_p0  <= '0;
    end else if (load) begin
      vld_p0 <= 1'b1;
      rd_p0  <= load_rd;
    end else if (clear) begin
      vld_p0 <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (load) data_p0 <= load_data;
  end

  assign valid = vld_p0;
  assign rd    = rd_p0;
  assign data  = data_p0;

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, MDU
// results wait in a one-entry buffer and force a one-cycle stall if starved.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int REG_WIDTH    = WB_REG_WIDTH,
  parameter int ADDR_WIDTH   = WB_ADDR_WIDTH,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  pipe_wb_valid,
  input  logic [ADDR_WIDTH-1:0] pipe_wb_rd,
  input  logic [REG_WIDTH-1:0]  pipe_wb_data,
  output logic                  pipe_wb_stall,
  input  logic                  mdu_valid,
  output logic                  mdu_ready,
  input  logic [ADDR_WIDTH-1:0] mdu_rd,
  input  logic [REG_WIDTH-1:0]  mdu_data,
  output logic                  mdu_pend_valid,
  output logic [ADDR_WIDTH-1:0] mdu_pend_rd,
  output logic                  rf_we,
  output logic [ADDR_WIDTH-1:0] rf_waddr,
  output logic [REG_WIDTH-1:0]  rf_wdata
);

  localparam logic [ADDR_WIDTH-1:0]   ZERO_RD   = ADDR_WIDTH'(X0_REG);
  localparam logic [STARVE_CNT_W-1:0] LIMIT_CNT = STARVE_CNT_W'(STARVE_LIMIT);
  localparam logic [STARVE_CNT_W-1:0] CNT_MAX   = '1;

  function automatic logic [STARVE_CNT_W-1:0] sat_inc(input logic [STARVE_CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  wb_state_e                state_q, state_d;
  logic [STARVE_CNT_W-1:0]  starve_q, starve_d;
  logic                     pipe_req, mdu_req;
  logic                     grant_pipe, grant_mdu;
  logic                     buf_load, buf_clear;
  logic                     buf_valid;
  logic [ADDR_WIDTH-1:0]    buf_rd;
  logic [REG_WIDTH-1:0]     buf_data;

  logic                     vld_p1;
  logic [ADDR_WIDTH-1:0]    waddr_p1;
  logic [REG_WIDTH-1:0]     wdata_p1;

  assign pipe_req = pipe_wb_valid && (pipe_wb_rd != ZERO_RD);
  assign mdu_req  = mdu_valid && (mdu_rd != ZERO_RD);

  wb_hold_buf #(
    .REG_WIDTH (REG_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_hold_buf (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (buf_load),
    .clear    (buf_clear),
    .load_rd  (mdu_rd),
    .load_data(mdu_data),
    .valid    (buf_valid),
    .rd       (buf_rd),
    .data     (buf_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    starve_d      = starve_q;
    grant_pipe    = 1'b0;
    grant_mdu     = 1'b0;
    buf_load      = 1'b0;
    buf_clear     = 1'b0;
    pipe_wb_stall = 1'b0;
    mdu_ready     = 1'b0;
    unique case (state_q)
      IDLE: begin
        mdu_ready  = 1'b1;
        grant_pipe = pipe_req;
        // An MDU result aimed at x0 is accepted and dropped here.
        if (mdu_req) begin
          buf_load = 1'b1;
          starve_d = '0;
          state_d  = HOLD;
        end
      end
      HOLD: begin
        if (!pipe_req) begin
          grant_mdu = 1'b1;
          buf_clear = 1'b1;
          state_d   = IDLE;
        end else if (pipe_wb_rd == buf_rd) begin
          // The younger pipeline write makes the buffered MDU value dead.
          grant_pipe = 1'b1;
          buf_clear  = 1'b1;
          state_d    = IDLE;
        end else begin
          grant_pipe = 1'b1;
          starve_d   = sat_inc(starve_q);
          if (sat_inc(starve_q) == LIMIT_CNT) state_d = FORCE;
        end
      end
      FORCE: begin
        pipe_wb_stall = 1'b1;
        grant_mdu     = 1'b1;
        buf_clear     = 1'b1;
        starve_d      = '0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write stage: winner of this cycle reaches the register file next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1   <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= grant_pipe || grant_mdu;
      if (grant_pipe) begin
        waddr_p1 <= pipe_wb_rd;
        wdata_p1 <= pipe_wb_data;
      end else if (grant_mdu) begin
        waddr_p1 <= buf_rd;
        wdata_p1 <= buf_data;
      end
    end
  end

  assign rf_we          = vld_p1;
  assign rf_waddr       = waddr_p1;
  assign rf_wdata       = wdata_p1;
  assign mdu_pend_valid = buf_valid;
  assign mdu_pend_rd    = buf_rd;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with hand-computed expected values.
module tb_wb_port_arbiter;

  localparam int RW = 32;
  localparam int AW = 5;

  logic          clk;
  logic          reset_n;
  logic          pipe_wb_valid;
  logic [AW-1:0] pipe_wb_rd;
  logic [RW-1:0] pipe_wb_data;
  logic          pipe_wb_stall;
  logic          mdu_valid;
  logic          mdu_ready;
  logic [AW-1:0] mdu_rd;
  logic [RW-1:0] mdu_data;
  logic          mdu_pend_valid;
  logic [AW-1:0] mdu_pend_rd;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [RW-1:0] rf_wdata;

  int n_vec  = 0;
  int n_miss = 0;

  wb_port_arbiter #(
    .REG_WIDTH   (RW),
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(4)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pipe_wb_valid (pipe_wb_valid),
    .pipe_wb_rd    (pipe_wb_rd),
    .pipe_wb_data  (pipe_wb_data),
    .pipe_wb_stall (pipe_wb_stall),
    .mdu_valid     (mdu_valid),
    .mdu_ready     (mdu_ready),
    .mdu_rd        (mdu_rd),
    .mdu_data      (mdu_data),
    .mdu_pend_valid(mdu_pend_valid),
    .mdu_pend_rd   (mdu_pend_rd),
    .rf_we         (rf_we),
    .rf_waddr      (rf_waddr),
    .rf_wdata      (rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rf(input string tag, input logic we, input logic [AW-1:0] a, input logic [RW-1:0] d);
    check_vec({tag, ".we"}, 64'(rf_we), 64'(we));
    if (we) begin
      check_vec({tag, ".waddr"}, 64'(rf_waddr), 64'(a));
      check_vec({tag, ".wdata"}, 64'(rf_wdata), 64'(d));
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check_vec({tag, ".stall"}, 64'(pipe_wb_stall), 64'd0);
    check_vec({tag, ".ready"}, 64'(mdu_ready), 64'd1);
    check_vec({tag, ".pend_valid"}, 64'(mdu_pend_valid), 64'd0);
  endtask

  initial begin
    reset_n       = 1'b0;
    pipe_wb_valid = 1'b0;
    pipe_wb_rd    = '0;
    pipe_wb_data  = '0;
    mdu_valid     = 1'b0;
    mdu_rd        = '0;
    mdu_data      = '0;
    tick();
    tick();

    // Reset values
    check_vec("rst.we", 64'(rf_we), 64'd0);
    check_vec("rst.waddr", 64'(rf_waddr), 64'd0);
    check_vec("rst.wdata", 64'(rf_wdata), 64'd0);
    check_vec("rst.pend_rd", 64'(mdu_pend_rd), 64'd0);
    check_idle_outs("rst");
    reset_n = 1'b1;
    tick();
    check_rf("rst.quiet", 1'b0, '0, '0);

    // Pipe only
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd5; pipe_wb_data = 32'hDEAD_BEEF;
    tick();
    check_rf("pipe", 1'b1, 5'd5, 32'hDEAD_BEEF);
    check_vec("pipe.ready", 64'(mdu_ready), 64'd1);
    pipe_wb_valid = 1'b0;
    tick();
    check_rf("pipe.after", 1'b0, '0, '0);

    // MDU on an idle port
    mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_data = 32'h1234;
    check_vec("mdu.ready_in", 64'(mdu_ready), 64'd1);
    tick();
    mdu_valid = 1'b0;
    check_rf("mdu.load", 1'b0, '0, '0);
    check_vec("mdu.pend_valid", 64'(mdu_pend_valid), 64'd1);
    check_vec("mdu.pend_rd", 64'(mdu_pend_rd), 64'd7);
    check_vec("mdu.ready_busy", 64'(mdu_ready), 64'd0);
    tick();
    check_rf("mdu.write", 1'b1, 5'd7, 32'h1234);
    check_idle_outs("mdu.done");

    // Starvation with STARVE_LIMIT=4
    mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_data = 32'h9999;
    tick();
    mdu_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      pipe_wb_valid = 1'b1; pipe_wb_rd = AW'(i); pipe_wb_data = 32'h100 + 32'(i);
      tick();
      check_rf($sformatf("starve.p%0d", i), 1'b1, AW'(i), 32'h100 + 32'(i));
      check_vec($sformatf("starve.stall%0d", i), 64'(pipe_wb_stall), 64'(i == 4));
    end
    check_vec("starve.force_pend", 64'(mdu_pend_valid), 64'd1);
    check_vec("starve.force_ready", 64'(mdu_ready), 64'd0);
    pipe_wb_rd = 5'd5; pipe_wb_data = 32'h105;
    tick();
    check_rf("starve.mdu", 1'b1, 5'd9, 32'h9999);
    check_vec("starve.stall_end", 64'(pipe_wb_stall), 64'd0);
    tick();
    check_rf("starve.replay", 1'b1, 5'd5, 32'h105);
    pipe_wb_valid = 1'b0;
    tick();
    check_rf("starve.quiet", 1'b0, '0, '0);

    // WAW cancel
    mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_data = 32'h3333;
    tick();
    mdu_valid = 1'b0;
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd3; pipe_wb_data = 32'hAAAA;
    tick();
    check_rf("waw.pipe", 1'b1, 5'd3, 32'hAAAA);
    check_vec("waw.pend_valid", 64'(mdu_pend_valid), 64'd0);
    pipe_wb_valid = 1'b0;
    tick();
    check_rf("waw.no_mdu", 1'b0, '0, '0);
    check_idle_outs("waw.idle");

    // x0 destinations
    mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_data = 32'h5555;
    tick();
    mdu_valid = 1'b0;
    check_rf("x0.mdu", 1'b0, '0, '0);
    check_idle_outs("x0.mdu");
    tick();
    check_rf("x0.mdu2", 1'b0, '0, '0);
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd0; pipe_wb_data = 32'h6666;
    tick();
    pipe_wb_valid = 1'b0;
    check_rf("x0.pipe", 1'b0, '0, '0);
    check_idle_outs("x0.pipe");

    // Same-cycle pipe and MDU in IDLE: pipe writes, MDU buffered then written
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd10; pipe_wb_data = 32'hA0;
    mdu_valid = 1'b1; mdu_rd = 5'd11; mdu_data = 32'hB0;
    tick();
    pipe_wb_valid = 1'b0; mdu_valid = 1'b0;
    check_rf("both.pipe", 1'b1, 5'd10, 32'hA0);
    tick();
    check_rf("both.mdu", 1'b1, 5'd11, 32'hB0);

    // Reset while holding a result
    mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_data = 32'hC0C0;
    tick();
    mdu_valid = 1'b0;
    check_vec("rsthold.pend_rd", 64'(mdu_pend_rd), 64'd12);
    reset_n = 1'b0;
    #1;
    check_vec("rsthold.we", 64'(rf_we), 64'd0);
    check_vec("rsthold.waddr", 64'(rf_waddr), 64'd0);
    check_vec("rsthold.wdata", 64'(rf_wdata), 64'd0);
    check_vec("rsthold.pend_rd0", 64'(mdu_pend_rd), 64'd0);
    check_idle_outs("rsthold.async");
    tick();
    reset_n = 1'b1;
    tick();
    check_rf("rsthold.post1", 1'b0, '0, '0);
    check_idle_outs("rsthold.post1");
    tick();
    check_rf("rsthold.post2", 1'b0, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
